// File: rtl/flags_pkg.sv
// flags_pkg: shared constants for the status-flag register and its save stack.
//   FLAG_C/N/Z/V : bit positions of carry, negative, zero and overflow
//   DEF_WIDTH    : default number of flag bits
//   DEF_DEPTH    : default number of save-stack entries
package flags_pkg;

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 3;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_DEPTH = 4;

endpackage

// File: rtl/flags_lifo.sv
// flags_lifo: LIFO save stack for flag context.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (clears count only)
//   push     : save din on the stack
//   pop      : request removal of the top entry
//   din      : value to save (current flags)
//   top      : current top entry (valid only when !empty)
//   count    : occupied entries
//   empty    : count == 0
//   full     : count == DEPTH
//   pop_ok   : pop accepted this cycle
// A push together with an accepted pop overwrites the top entry in place
// (swap), leaving count unchanged.
module flags_lifo
    import flags_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             pop_ok
);

    // Storage is rounded up to a power of two so the index has an exact width;
    // slots at or above DEPTH are never addressed.
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SLOTS = 1 << AW;

    logic [WIDTH-1:0] mem [SLOTS];
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_idx;
    logic             push_ok;

    always_comb begin
        empty   = (count == '0);
        full    = (count == CW'(DEPTH));
        pop_ok  = pop && !empty;
        // A pop frees the top slot in the same cycle, so push is accepted even when full.
        push_ok = push && (!full || pop_ok);
        top_idx = AW'(count - CW'(1));
        wr_idx  = pop_ok ? top_idx : AW'(count);
        top     = mem[top_idx];
    end

    // Storage has no reset; count guarantees no entry is read before written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_idx] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (push_ok && !pop_ok) begin
            count <= count + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/flags_stack.sv
// flags_stack: processor status-flag register with per-bit write mask,
// carry set/clear and a LIFO save/restore stack.
// Optional feature macro: FLAGS_CHK_EN (adds sticky err port, misuse
// detection and a simulation check that sc and cc are not both asserted).
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   load     : merge in into flags under mask
//   mask     : per-bit write enable for load
//   in       : flag values from ALU
//   sc, cc   : force carry to 1 / 0 (sc wins)
//   push     : save current flags onto the stack
//   pop      : restore flags from the stack top (overrides load/sc/cc)
//   out      : registered current flags
//   count    : occupied stack entries
//   empty    : count == 0
//   full     : count == DEPTH
//   err      : sticky misuse flag (FLAGS_CHK_EN only)
module flags_stack
    import flags_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] mask,
    input  logic [WIDTH-1:0] in,
    input  logic             sc,
    input  logic             cc,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] out,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
`ifdef FLAGS_CHK_EN
    ,
    output logic             err
`endif
);

    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] nxt;
    logic             pop_ok;

    flags_lifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .din    (out),
        .top    (top),
        .count  (count),
        .empty  (empty),
        .full   (full),
        .pop_ok (pop_ok)
    );

    always_comb begin
        base = load ? ((out & ~mask) | (in & mask)) : out;
        nxt  = base;
        if (sc) begin
            nxt[FLAG_C] = 1'b1;
        end else if (cc) begin
            nxt[FLAG_C] = 1'b0;
        end
        if (pop_ok) begin
            nxt = top;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= '0;
        end else begin
            out <= nxt;
        end
    end

`ifdef FLAGS_CHK_EN
    logic misuse;

    assign misuse = (push && full && !pop) || (pop && empty);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (misuse) begin
            err <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(sc && cc))
            else $warning("flags_stack: sc and cc asserted in the same cycle");
        end
    end
`endif
`endif

endmodule

// File: tb/tb_flags_stack.sv
module tb_flags_stack;

    typedef struct packed {
        logic       l;
        logic [3:0] mk;
        logic [3:0] i;
        logic       s;
        logic       c;
        logic       ps;
        logic       pp;
    } stim_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [3:0] mask = '0;
    logic [3:0] in = '0;
    logic       sc = 1'b0;
    logic       cc = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [3:0] out;
    logic [2:0] count;
    logic       empty;
    logic       full;
`ifdef FLAGS_CHK_EN
    logic       err;
`endif

    logic [8:0] obs;
    assign obs = {out, count, empty, full};

    // Reference model state
    logic [3:0] m_out = '0;
    logic [3:0] m_stk[$];
    logic       m_err = 1'b0;
    logic [8:0] sb[$];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    flags_stack #(
        .WIDTH (4),
        .DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .mask  (mask),
        .in    (in),
        .sc    (sc),
        .cc    (cc),
        .push  (push),
        .pop   (pop),
        .out   (out),
        .count (count),
        .empty (empty),
        .full  (full)
`ifdef FLAGS_CHK_EN
        ,
        .err   (err)
`endif
    );

    // Updates the model, queues the expected outputs and clocks one command.
    task automatic apply(input stim_t st);
        int         sz;
        bit         pop_ok;
        bit         push_ok;
        logic [3:0] nxt;
        sz      = m_stk.size();
        pop_ok  = st.pp && (sz > 0);
        push_ok = st.ps && ((sz < 4) || pop_ok);
        if (pop_ok) begin
            nxt = m_stk[sz-1];
        end else begin
            nxt = st.l ? ((m_out & ~st.mk) | (st.i & st.mk)) : m_out;
            if (st.s) nxt[0] = 1'b1;
            else if (st.c) nxt[0] = 1'b0;
        end
        if ((st.ps && sz == 4 && !st.pp) || (st.pp && sz == 0)) m_err = 1'b1;
        if (push_ok && pop_ok) m_stk[sz-1] = m_out;
        else if (push_ok) m_stk.push_back(m_out);
        else if (pop_ok) void'(m_stk.pop_back());
        m_out = nxt;
        sb.push_back({m_out, 3'(m_stk.size()), m_stk.size() == 0, m_stk.size() == 4});
        load = st.l; mask = st.mk; in = st.i; sc = st.s; cc = st.c; push = st.ps; pop = st.pp;
        @(posedge clk);
        #1;
        load = 1'b0; mask = '0; in = '0; sc = 1'b0; cc = 1'b0; push = 1'b0; pop = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        @(negedge clk);
        rst = 1'b0;
        m_out = '0;
        m_stk.delete();
        m_err = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t      tbl[2];
        logic [8:0] e;
        do_reset();
        vectors++;
        if (obs !== 9'b0000_000_1_0) begin
            miscompares++;
            $display("FAIL reset_init: {out,count,empty,full} got %b want %b", obs, 9'b0000_000_1_0);
        end
        tbl[0] = '{l:1'b1, mk:4'hF, i:4'b0011, s:1'b0, c:1'b0, ps:1'b1, pp:1'b0};
        tbl[1] = '{l:1'b1, mk:4'hF, i:4'b1010, s:1'b0, c:1'b0, ps:1'b1, pp:1'b0};
        for (int k = 0; k < 2; k++) begin
            apply(tbl[k]);
            e = sb.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL reset_push[%0d]: {out,count,empty,full} got %b want %b", k, obs, e);
            end
        end
        // Asynchronous assertion: outputs must clear without a clock edge.
        rst = 1'b1;
        #2;
        vectors++;
        if (obs !== 9'b0000_000_1_0) begin
            miscompares++;
            $display("FAIL reset_async: {out,count,empty,full} got %b want %b", obs, 9'b0000_000_1_0);
        end
`ifdef FLAGS_CHK_EN
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_err: err got %b want 0", err);
        end
`endif
        do_reset();
    endtask

    task automatic test_masked_load();
        stim_t      tbl[2];
        logic [8:0] e;
        do_reset();
        tbl[0] = '{l:1'b1, mk:4'b0101, i:4'b1111, s:1'b0, c:1'b0, ps:1'b0, pp:1'b0};
        tbl[1] = '{l:1'b0, mk:4'b0000, i:4'b0000, s:1'b1, c:1'b1, ps:1'b0, pp:1'b0};
        for (int k = 0; k < 2; k++) begin
            apply(tbl[k]);
            e = sb.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL masked_load[%0d]: {out,count,empty,full} got %b want %b", k, obs, e);
            end
            vectors++;
            if (out !== 4'b0101) begin
                miscompares++;
                $display("FAIL masked_load_const[%0d]: out got %b want 0101", k, out);
            end
        end
        // cc alone clears carry without touching the other bits.
        apply('{l:1'b0, mk:4'b0000, i:4'b0000, s:1'b0, c:1'b1, ps:1'b0, pp:1'b0});
        e = sb.pop_front();
        vectors++;
        if (out !== 4'b0100 || obs !== e) begin
            miscompares++;
            $display("FAIL clear_carry: {out,count,empty,full} got %b want %b", obs, e);
        end
    endtask

    task automatic test_nested();
        stim_t      tbl[7];
        logic [8:0] e;
        do_reset();
        tbl[0] = '{l:1'b1, mk:4'hF, i:4'b0011, s:1'b0, c:1'b0, ps:1'b0, pp:1'b0};
        tbl[1] = '{l:1'b0, mk:4'h0, i:4'b0000, s:1'b0, c:1'b0, ps:1'b1, pp:1'b0};
        tbl[2] = '{l:1'b1, mk:4'hF, i:4'b1100, s:1'b0, c:1'b0, ps:1'b0, pp:1'b0};
        tbl[3] = '{l:1'b0, mk:4'h0, i:4'b0000, s:1'b0, c:1'b0, ps:1'b1, pp:1'b0};
        tbl[4] = '{l:1'b1, mk:4'hF, i:4'b0000, s:1'b0, c:1'b0, ps:1'b0, pp:1'b0};
        tbl[5] = '{l:1'b0, mk:4'h0, i:4'b0000, s:1'b0, c:1'b0, ps:1'b0, pp:1'b1};
        tbl[6] = '{l:1'b0, mk:4'h0, i:4'b0000, s:1'b0, c:1'b0, ps:1'b0, pp:1'b1};
        for (int k = 0; k < 7; k++) begin
            apply(tbl[k]);
            e = sb.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL nested[%0d]: {out,count,empty,full} got %b want %b", k, obs, e);
            end
            if (k == 5) begin
                vectors++;
                if (out !== 4'b1100 || count !== 3'd1) begin
                    miscompares++;
                    $display("FAIL nested_pop1: out/count got %b/%0d want 1100/1", out, count);
                end
            end
        end
        vectors++;
        if (out !== 4'b0011 || empty !== 1'b1) begin
            miscompares++;
            $display("FAIL nested_pop2: out/empty got %b/%b want 0011/1", out, empty);
        end
    endtask

    task automatic test_swap();
        stim_t      tbl[5];
        logic [8:0] e;
        do_reset();
        tbl[0] = '{l:1'b1, mk:4'hF, i:4'b1000, s:1'b0, c:1'b0, ps:1'b0, pp:1'b0};
        tbl[1] = '{l:1'b0, mk:4'h0, i:4'b0000, s:1'b0, c:1'b0, ps:1'b1, pp:1'b0};
        tbl[2] = '{l:1'b1, mk:4'hF, i:4'b0001, s:1'b0, c:1'b0, ps:1'b0, pp:1'b0};
        tbl[3] = '{l:1'b1, mk:4'hF, i:4'b0111, s:1'b0, c:1'b0, ps:1'b1, pp:1'b1};
        tbl[4] = '{l:1'b0, mk:4'h0, i:4'b0000, s:1'b0, c:1'b0, ps:1'b0, pp:1'b1};
        for (int k = 0; k < 5; k++) begin
            apply(tbl[k]);
            e = sb.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL swap[%0d]: {out,count,empty,full} got %b want %b", k, obs, e);
            end
            if (k == 3) begin
                vectors++;
                if (out !== 4'b1000 || count !== 3'd1) begin
                    miscompares++;
                    $display("FAIL swap_exchange: out/count got %b/%0d want 1000/1", out, count);
                end
            end
        end
        vectors++;
        if (out !== 4'b0001 || count !== 3'd0) begin
            miscompares++;
            $display("FAIL swap_top: out/count got %b/%0d want 0001/0", out, count);
        end
        // push+pop on an empty stack degrades to a plain push; flags still load.
        apply('{l:1'b1, mk:4'hF, i:4'b1010, s:1'b0, c:1'b0, ps:1'b1, pp:1'b1});
        e = sb.pop_front();
        vectors++;
        if (obs !== e || out !== 4'b1010 || count !== 3'd1) begin
            miscompares++;
            $display("FAIL swap_empty: {out,count,empty,full} got %b want %b", obs, e);
        end
    endtask

    task automatic test_overflow();
        logic [8:0] e;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            apply('{l:1'b1, mk:4'hF, i:4'(k + 1), s:1'b0, c:1'b0, ps:1'b1, pp:1'b0});
            e = sb.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL overflow_push[%0d]: {out,count,empty,full} got %b want %b", k, obs, e);
            end
        end
        vectors++;
        if (count !== 3'd4 || full !== 1'b1 || out !== 4'd5) begin
            miscompares++;
            $display("FAIL overflow_full: out/count/full got %b/%0d/%b want 0101/4/1", out, count, full);
        end
`ifdef FLAGS_CHK_EN
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_err: err got %b want 1", err);
        end
`endif
        for (int k = 0; k < 4; k++) begin
            apply('{l:1'b0, mk:4'h0, i:4'h0, s:1'b0, c:1'b0, ps:1'b0, pp:1'b1});
            e = sb.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL overflow_pop[%0d]: {out,count,empty,full} got %b want %b", k, obs, e);
            end
        end
        do_reset();
        apply('{l:1'b1, mk:4'hF, i:4'b0110, s:1'b0, c:1'b0, ps:1'b0, pp:1'b1});
        e = sb.pop_front();
        vectors++;
        if (obs !== e || out !== 4'b0110 || count !== 3'd0) begin
            miscompares++;
            $display("FAIL underflow: {out,count,empty,full} got %b want %b", obs, e);
        end
`ifdef FLAGS_CHK_EN
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL underflow_err: err got %b want 1", err);
        end
`endif
    endtask

    task automatic test_pop_priority();
        stim_t      tbl[4];
        logic [8:0] e;
        do_reset();
        tbl[0] = '{l:1'b1, mk:4'hF, i:4'b0100, s:1'b0, c:1'b0, ps:1'b0, pp:1'b0};
        tbl[1] = '{l:1'b0, mk:4'h0, i:4'b0000, s:1'b0, c:1'b0, ps:1'b1, pp:1'b0};
        tbl[2] = '{l:1'b1, mk:4'hF, i:4'b0000, s:1'b0, c:1'b0, ps:1'b0, pp:1'b0};
        tbl[3] = '{l:1'b1, mk:4'hF, i:4'b1111, s:1'b1, c:1'b0, ps:1'b0, pp:1'b1};
        for (int k = 0; k < 4; k++) begin
            apply(tbl[k]);
            e = sb.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL pop_priority[%0d]: {out,count,empty,full} got %b want %b", k, obs, e);
            end
        end
        vectors++;
        if (out !== 4'b0100) begin
            miscompares++;
            $display("FAIL pop_priority_const: out got %b want 0100", out);
        end
    endtask

    task automatic test_back_to_back();
        stim_t      st;
        logic [8:0] e;
        do_reset();
        for (int k = 0; k < 300; k++) begin
            st.l  = 1'($urandom_range(0, 1));
            st.mk = 4'($urandom);
            st.i  = 4'($urandom);
            st.s  = ($urandom_range(0, 7) == 0);
            st.c  = !st.s && ($urandom_range(0, 7) == 0);
            st.ps = 1'($urandom_range(0, 1));
            st.pp = 1'($urandom_range(0, 1));
            apply(st);
            e = sb.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: {out,count,empty,full} got %b want %b", k, obs, e);
            end
`ifdef FLAGS_CHK_EN
            vectors++;
            if (err !== m_err) begin
                miscompares++;
                $display("FAIL back_to_back_err[%0d]: err got %b want %b", k, err, m_err);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_masked_load();
        test_nested();
        test_swap();
        test_overflow();
        test_pop_priority();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
